// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the SRAM data-memory controller
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_e;

    localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;
    localparam int          SRAM_ADDR_W       = 18;
    localparam int          SRAM_DATA_W       = 16;

endpackage

// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - MEM-stage word request/response bus
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_addr_map.sv
// rtl/sram_addr_map.sv - byte address to SRAM halfword address mapping
module sram_addr_map
    import sram_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DATA_BASE_DEFAULT
) (
    input  logic [31:0]            byte_addr,
    input  logic                   phase_hi,
    output logic [SRAM_ADDR_W-1:0] sram_addr
);
    logic [31:0] offset;
    logic        unused_offset_bits;

    // Wrapping subtraction: addresses below DATA_BASE alias high in SRAM.
    assign offset             = byte_addr - DATA_BASE;
    assign sram_addr          = {offset[18:2], phase_hi};
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - two-halfword SRAM responder for MEM-stage word accesses; SRAM_ACCESS_COUNT_EN adds access counters
module sram_controller
    import sram_pkg::*;
#(
    parameter int          PHASE_CYCLES = 2,
    parameter logic [31:0] DATA_BASE    = DATA_BASE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
`ifdef SRAM_ACCESS_COUNT_EN
    ,
    output logic [31:0]            read_count,
    output logic [31:0]            write_count
`endif
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_LOW  = LOW;
    localparam logic [1:0] S_HIGH = HIGH;
    localparam logic [1:0] S_DONE = DONE;
    localparam int         CNT_W  = $clog2(PHASE_CYCLES);

    logic [1:0]             state;
    logic [CNT_W-1:0]       phase_cnt;
    logic                   op_write;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic                   active;
    logic                   phase_hi;
    logic                   last_cycle;
    logic [SRAM_ADDR_W-1:0] mapped_addr;
    logic [SRAM_DATA_W-1:0] wdata_half;

    assign active     = (state == S_LOW) || (state == S_HIGH);
    assign phase_hi   = (state == S_HIGH);
    assign last_cycle = (phase_cnt == CNT_W'(PHASE_CYCLES - 1));
    assign wdata_half = phase_hi ? wdata_q[31:16] : wdata_q[15:0];

    sram_addr_map #(.DATA_BASE(DATA_BASE)) u_addr_map (
        .byte_addr (addr_q),
        .phase_hi  (phase_hi),
        .sram_addr (mapped_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            phase_cnt     <= '0;
            op_write      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.read_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.rd_en || bus.wr_en) begin
                        op_write  <= bus.wr_en;
                        addr_q    <= bus.address;
                        wdata_q   <= bus.write_data;
                        phase_cnt <= '0;
                        state     <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (last_cycle) begin
                        if (!op_write) bus.read_data[15:0] <= SRAM_DQ;
                        phase_cnt <= '0;
                        state     <= S_HIGH;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (last_cycle) begin
                        if (!op_write) bus.read_data[31:16] <= SRAM_DQ;
                        phase_cnt <= '0;
                        state     <= S_DONE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SRAM_ACCESS_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (state == S_DONE) begin
            if (op_write) write_count <= write_count + 32'd1;
            else          read_count  <= read_count + 32'd1;
        end
    end
`endif

    // WE_N rises on the last cycle of each phase so data is held past the write edge.
    assign SRAM_ADDR = active ? mapped_addr : '0;
    assign SRAM_CE_N = ~active;
    assign SRAM_UB_N = ~active;
    assign SRAM_LB_N = ~active;
    assign SRAM_OE_N = ~(active & ~op_write);
    assign SRAM_WE_N = ~(active & op_write & ~last_cycle);
    assign SRAM_DQ   = (active && op_write) ? wdata_half : {SRAM_DATA_W{1'bz}};

    assign bus.ready = ~((state == S_IDLE) & (bus.rd_en | bus.wr_en))
                       & (state != S_LOW) & (state != S_HIGH);
endmodule
